noc_port_requester: RTL and testbench

Requester side of the router's per-port arbitration handshake: it takes whole packets from an input-port flit FIFO, raises the request toward the five-way arbiter, and tags each flit with a flit id and the packet length so that the arbiter's per-port timeout timer loads correctly. When the arbiter grants the port, it streams flits to the crossbar. If the timeout revokes the grant mid-packet, it holds the packet and keeps requesting. One instance sits on each of the L, N, E, W and S input ports.

---
 rtl/noc_port_requester.sv | 131 +++++++++++++
 tb/tb_noc_port_requester.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/noc_port_requester.sv
// Per-port requester: pulls whole packets from the input FIFO, requests the arbiter, and streams granted flits to the crossbar.
// Optional REQ_STALL_CNT_EN adds the stall_cycles counter (cycles spent requesting without a grant).
module noc_port_requester #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  grant,
   output logic                  req,
   output logic [2:0]            flit_id,
   output logic [11:0]           length,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid
`ifdef REQ_STALL_CNT_EN
   ,
   output logic [15:0]           stall_cycles
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_GNT, S_XFER, S_HOLD} state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [11:0] r_len_q;
   logic [11:0] r_flit_cnt;
   logic [11:0] w_raw_len;
   logic [11:0] w_eff_len;
   logic [11:0] w_cur_len;
   logic [2:0]  w_flit_id;
   logic        w_xfer;
   logic        w_is_tail;

   assign w_raw_len = in_data[11:0];
   assign w_eff_len = (w_raw_len < 12'd2) ? 12'd2 : w_raw_len;
   // While waiting for the grant the header is still at the FIFO head, so its length is read live.
   assign w_cur_len = (r_state == S_WAIT_GNT) ? w_eff_len : r_len_q;
   assign w_xfer    = grant && in_valid && ((r_state == S_WAIT_GNT) || (r_state == S_XFER));
   assign w_is_tail = (r_flit_cnt == (w_cur_len - 12'd1));
   assign out_data  = in_data;

   always_comb begin
      w_flit_id = 3'b010;
      if (r_flit_cnt == 12'd0) begin
         w_flit_id = 3'b001;
      end else if (w_is_tail) begin
         w_flit_id = 3'b100;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_len_q    <= 12'd0;
         r_flit_cnt <= 12'd0;
      end else begin
         if (((r_state == S_WAIT_GNT) && grant) || (w_xfer && (r_flit_cnt == 12'd0))) begin
            r_len_q <= w_eff_len;
         end
         if (w_xfer) begin
            r_flit_cnt <= w_is_tail ? 12'd0 : (r_flit_cnt + 12'd1);
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (in_valid) w_state_next = S_WAIT_GNT;
         end
         S_WAIT_GNT: begin
            if (grant) w_state_next = S_XFER;
         end
         S_XFER: begin
            // A tail leaving in the same cycle the grant drops still completes the packet.
            if (w_xfer && w_is_tail) begin
               w_state_next = S_IDLE;
            end else if (!grant) begin
               w_state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (grant) w_state_next = S_XFER;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      req       = 1'b0;
      flit_id   = 3'b000;
      length    = 12'd0;
      in_ready  = w_xfer;
      out_valid = w_xfer;
      case (r_state)
         S_WAIT_GNT, S_XFER, S_HOLD: begin
            req     = 1'b1;
            flit_id = w_flit_id;
            length  = w_cur_len;
         end
         default: begin
            req = 1'b0;
         end
      endcase
   end

`ifdef REQ_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= 16'd0;
      end else if (req && !grant && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_noc_port_requester.sv
// Self-checking bench for noc_port_requester: directed scenarios plus random FIFO/grant traffic against a packet-level model.
module tb_noc_port_requester;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        grant;
   logic        req;
   logic [2:0]  flit_id;
   logic [11:0] length;
   logic [31:0] out_data;
   logic        out_valid;
`ifdef REQ_STALL_CNT_EN
   logic [15:0] stall_cycles;
`endif

   noc_port_requester #(.DATA_WIDTH(32)) dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .grant(grant),
      .req(req),
      .flit_id(flit_id),
      .length(length),
      .out_data(out_data),
      .out_valid(out_valid)
`ifdef REQ_STALL_CNT_EN
      ,
      .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Packet-level model state: FIFO contents, per-packet effective lengths, progress of the packet at the head.
   logic [31:0] fifo_q[$];
   int          pkt_len_q[$];
   logic [2:0]  xfer_ids[$];
   bit          pkt_req = 1'b0;
   bit          seen_grant = 1'b0;
   bit          prev_g = 1'b0;
   int          sent = 0;
   int          stall_model = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [2:0] id_of(input int pos, input int len);
      if (pos == 0) return 3'b001;
      if (pos == len - 1) return 3'b100;
      return 3'b010;
   endfunction

   task automatic push_pkt(input int raw);
      logic [31:0] w;
      int          eff;
      eff = (raw < 2) ? 2 : raw;
      w = $urandom();
      w[11:0] = raw[11:0];
      fifo_q.push_back(w);
      for (int i = 1; i < eff; i++) begin
         w = $urandom();
         fifo_q.push_back(w);
      end
      pkt_len_q.push_back(eff);
   endtask

   // One clock cycle: drive at the falling edge, check 1 time unit later, advance the model, then cross the rising edge.
   task automatic cycle(input bit g, input bit ven, input bit r);
      bit         exp_xfer;
      bit         tail;
      int         cur_len;
      logic [2:0] exp_id;
      @(negedge clk);
      rst      = r;
      grant    = g;
      in_valid = (fifo_q.size() > 0) && ven;
      in_data  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
      #1;
      cur_len  = (pkt_len_q.size() > 0) ? pkt_len_q[0] : 0;
      exp_xfer = pkt_req && g && in_valid && (!seen_grant || prev_g);
      exp_id   = pkt_req ? id_of(sent, cur_len) : 3'b000;
      chk("req", {31'd0, req}, {31'd0, pkt_req});
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_xfer});
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_xfer});
      chk("out_data", out_data, in_data);
      chk("flit_id", {29'd0, flit_id}, {29'd0, exp_id});
      chk("length", {20'd0, length}, pkt_req ? cur_len : 32'd0);
`ifdef REQ_STALL_CNT_EN
      chk("stall_cycles", {16'd0, stall_cycles}, stall_model);
`endif
      if (r) begin
         fifo_q.delete();
         pkt_len_q.delete();
         pkt_req     = 1'b0;
         seen_grant  = 1'b0;
         sent        = 0;
         stall_model = 0;
      end else begin
         if (pkt_req && !g && stall_model < 65535) stall_model++;
         tail = 1'b0;
         if (exp_xfer) begin
            void'(fifo_q.pop_front());
            xfer_ids.push_back(exp_id);
            $display("xfer id=%03b len=%0d data=%08h", exp_id, cur_len, in_data);
            sent++;
            if (sent == cur_len) begin
               void'(pkt_len_q.pop_front());
               sent = 0;
               tail = 1'b1;
            end
         end
         if (pkt_req) begin
            if (tail) pkt_req = 1'b0;
            else seen_grant = seen_grant | g;
         end else if (in_valid) begin
            pkt_req    = 1'b1;
            seen_grant = 1'b0;
         end
      end
      prev_g = g;
      @(posedge clk);
   endtask

   task automatic chk_ids(input string tag, input logic [2:0] exp_ids[$]);
      chk({tag, "_count"}, xfer_ids.size(), exp_ids.size());
      for (int i = 0; i < exp_ids.size() && i < xfer_ids.size(); i++) begin
         chk(tag, {29'd0, xfer_ids[i]}, {29'd0, exp_ids[i]});
      end
   endtask

   initial begin
      rst = 1'b1;
      grant = 1'b0;
      in_valid = 1'b0;
      in_data = 32'h0;
      cycle(0, 0, 1);
      cycle(1, 0, 1);
      cycle(1, 0, 0);   // reset state, grant in IDLE ignored

      // Length 4, grant one cycle after req
      xfer_ids.delete();
      push_pkt(4);
      cycle(0, 1, 0);
      cycle(0, 1, 0);
      for (int i = 0; i < 4; i++) cycle(1, 1, 0);
      cycle(1, 1, 0);   // grant lingering after tail: req must be 0, no transfer
      chk_ids("len4_seq", '{3'b001, 3'b010, 3'b010, 3'b100});

      // Length 6, grant lost after flit 2 and restored 5 cycles later
      xfer_ids.delete();
      push_pkt(6);
      cycle(0, 1, 0);
      cycle(1, 1, 0);
      cycle(1, 1, 0);
      for (int i = 0; i < 5; i++) cycle(0, 1, 0);
      for (int i = 0; i < 5; i++) cycle(1, 1, 0);
      cycle(0, 0, 0);
      chk_ids("hold_seq", '{3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100});

      // Raw lengths 0 and 1 become 2-flit packets
      xfer_ids.delete();
      push_pkt(0);
      cycle(0, 1, 0);
      for (int i = 0; i < 3; i++) cycle(1, 1, 0);
      push_pkt(1);
      cycle(0, 1, 0);
      for (int i = 0; i < 3; i++) cycle(1, 1, 0);
      chk_ids("short_seq", '{3'b001, 3'b100, 3'b001, 3'b100});

      // Input bubble of 3 cycles with grant held
      xfer_ids.delete();
      push_pkt(5);
      cycle(0, 1, 0);
      cycle(1, 1, 0);
      cycle(1, 1, 0);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0);
      for (int i = 0; i < 4; i++) cycle(1, 1, 0);
      chk_ids("bubble_seq", '{3'b001, 3'b010, 3'b010, 3'b010, 3'b100});

      // Reset during the body of a length-8 packet, then a fresh packet
      push_pkt(8);
      cycle(0, 1, 0);
      for (int i = 0; i < 3; i++) cycle(1, 1, 0);
      cycle(1, 1, 1);
      cycle(1, 0, 0);
      xfer_ids.delete();
      push_pkt(3);
      cycle(0, 1, 0);
      for (int i = 0; i < 4; i++) cycle(1, 1, 0);
      chk_ids("post_rst_seq", '{3'b001, 3'b010, 3'b100});

      // Random traffic
      for (int c = 0; c < 2500; c++) begin
         if (fifo_q.size() < 6 && $urandom_range(0, 5) == 0) push_pkt($urandom_range(0, 12));
         cycle($urandom_range(0, 9) < 6, $urandom_range(0, 3) != 0, 1'b0);
      end
      for (int c = 0; c < 300 && (fifo_q.size() > 0 || pkt_req); c++) cycle(1, 1, 0);
      chk("drain_empty", fifo_q.size(), 0);
      chk("drain_idle", {31'd0, pkt_req}, 32'd0);

`ifdef REQ_STALL_CNT_EN
      cycle(0, 0, 1);
      push_pkt(4);
      cycle(0, 1, 0);
      for (int i = 0; i < 10; i++) cycle(0, 1, 0);
      #1;
      chk("stall10", {16'd0, stall_cycles}, 32'd10);
      for (int i = 0; i < 70000; i++) cycle(0, 1, 0);
      #1;
      chk("stall_sat", {16'd0, stall_cycles}, 32'hFFFF);
      cycle(0, 0, 1);
      cycle(0, 0, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
